// File: rtl/branch_pkg.sv
// Shared branch-unit types: branch type encodings and BHT constants.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_EQ     = 3'b000,
    BR_NE     = 3'b001,
    BR_NEVER  = 3'b010,
    BR_ALWAYS = 3'b011,
    BR_LT     = 3'b100,
    BR_GE     = 3'b101,
    BR_LTU    = 3'b110,
    BR_GEU    = 3'b111
  } br_type_e;

  localparam logic [1:0] BHT_RST = 2'b01;

  function automatic logic is_cond(input br_type_e t);
    return (t != BR_NEVER) && (t != BR_ALWAYS);
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: 2-bit saturating counters,
// one combinational lookup port and one update port.
module branch_bht
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lk_pc,
  output logic            lk_taken,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken
);

  localparam int IW = $clog2(DEPTH);

  logic [1:0]    cnt_q [DEPTH];
  logic [1:0]    cnt_d [DEPTH];
  logic [IW-1:0] lk_idx;
  logic [IW-1:0] upd_idx;
  logic          unused_pc;

  assign lk_idx  = lk_pc[IW+1:2];
  assign upd_idx = upd_pc[IW+1:2];
  assign unused_pc = ^{lk_pc[XLEN-1:IW+2], lk_pc[1:0],
                       upd_pc[XLEN-1:IW+2], upd_pc[1:0]};

  // Lookup reads the registered array, so a same-index
  // update in this cycle is not visible until next cycle.
  assign lk_taken = cnt_q[lk_idx][1];

  always_comb begin
    cnt_d = cnt_q;
    if (upd_en) begin
      if (upd_taken && cnt_q[upd_idx] != 2'b11)
        cnt_d[upd_idx] = cnt_q[upd_idx] + 2'd1;
      else if (!upd_taken && cnt_q[upd_idx] != 2'b00)
        cnt_d[upd_idx] = cnt_q[upd_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        cnt_q[i] <= BHT_RST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolve unit with 1-entry output register and BHT.
// Define BRANCH_STATS_EN to build the branch/mispredict counters.
module branch_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       br_type,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [XLEN-1:0]  pc,
  input  logic             pred_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             br_taken,
  output logic             mispredict,
  input  logic [XLEN-1:0]  lk_pc,
  output logic             lk_taken,
  output logic [CNT_W-1:0] stat_br,
  output logic [CNT_W-1:0] stat_mis
);

  br_type_e        bt;
  logic            eq, lt, ltu, taken;
  logic            accept, commit, upd_en;

  logic            out_valid_q, out_valid_d;
  logic            br_taken_q, br_taken_d;
  logic            mispredict_q, mispredict_d;
  br_type_e        type_q, type_d;
  logic [XLEN-1:0] pc_q, pc_d;

  assign bt  = br_type_e'(br_type);
  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      (bt == BR_EQ):     taken = eq;
      (bt == BR_NE):     taken = !eq;
      (bt == BR_NEVER):  taken = 1'b0;
      (bt == BR_ALWAYS): taken = 1'b1;
      (bt == BR_LT):     taken = lt;
      (bt == BR_GE):     taken = !lt;
      (bt == BR_LTU):    taken = ltu;
      (bt == BR_GEU):    taken = !ltu;
      default:           taken = 1'b0;
    endcase
  end

  assign in_ready = rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign commit   = out_valid_q && out_ready;
  assign upd_en   = commit && rst && is_cond(type_q);

  always_comb begin
    out_valid_d  = out_valid_q;
    br_taken_d   = br_taken_q;
    mispredict_d = mispredict_q;
    type_d       = type_q;
    pc_d         = pc_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      br_taken_d   = taken;
      mispredict_d = (taken != pred_in);
      type_d       = bt;
      pc_d         = pc;
    end else if (commit) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      br_taken_q   <= 1'b0;
      mispredict_q <= 1'b0;
      type_q       <= BR_NEVER;
      pc_q         <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      br_taken_q   <= br_taken_d;
      mispredict_q <= mispredict_d;
      type_q       <= type_d;
      pc_q         <= pc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign br_taken   = br_taken_q;
  assign mispredict = mispredict_q;

  branch_bht #(
    .XLEN  (XLEN),
    .DEPTH (BHT_DEPTH)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .lk_pc     (lk_pc),
    .lk_taken  (lk_taken),
    .upd_en    (upd_en),
    .upd_pc    (pc_q),
    .upd_taken (br_taken_q)
  );

`ifdef BRANCH_STATS_EN
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] stat_br_q, stat_br_d;
  logic [CNT_W-1:0] stat_mis_q, stat_mis_d;

  always_comb begin
    stat_br_d  = stat_br_q;
    stat_mis_d = stat_mis_q;
    if (upd_en) begin
      if (stat_br_q != '1)
        stat_br_d = stat_br_q + ONE;
      if (mispredict_q && stat_mis_q != '1)
        stat_mis_d = stat_mis_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_br  = stat_br_q;
  assign stat_mis = stat_mis_q;
`else
  assign stat_br  = '0;
  assign stat_mis = '0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit.
// Inputs driven and outputs sampled on the falling edge.
module tb_branch_unit;
  import branch_pkg::*;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  br_type;
  logic [31:0] a, b, pc, lk_pc;
  logic        pred_in;
  logic        out_valid;
  logic        out_ready;
  logic        br_taken;
  logic        mispredict;
  logic        lk_taken;
  logic [31:0] stat_br, stat_mis;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .br_type    (br_type),
    .a          (a),
    .b          (b),
    .pc         (pc),
    .pred_in    (pred_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .br_taken   (br_taken),
    .mispredict (mispredict),
    .lk_pc      (lk_pc),
    .lk_taken   (lk_taken),
    .stat_br    (stat_br),
    .stat_mis   (stat_mis)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] st(input int v);
    return STATS ? 64'(v) : 64'd0;
  endfunction

  task automatic drive(input logic [2:0] t,
                       input logic [31:0] av,
                       input logic [31:0] bv,
                       input logic [31:0] p,
                       input logic pr);
    in_valid = 1'b1;
    br_type  = t;
    a        = av;
    b        = bv;
    pc       = p;
    pred_in  = pr;
  endtask

  typedef struct {
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] b;
    logic        pr;
    logic        tk;
    logic        mis;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{BR_LT,     32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{BR_LTU,    32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{BR_GE,     32'hFFFF_FFFB, 32'hFFFF_FFFB, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{BR_GEU,    32'd0, 32'd1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{BR_NE,     32'd3, 32'd4, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{BR_EQ,     32'd3, 32'd4, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{BR_NEVER,  32'd7, 32'd7, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{BR_ALWAYS, 32'd0, 32'd9, 1'b0, 1'b1, 1'b1};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    br_type = 3'b000; a = '0; b = '0; pc = '0;
    pred_in = 1'b0; lk_pc = 32'h40;

    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_br_taken", br_taken, 0);
    check("rst_mispredict", mispredict, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_stat_br", stat_br, 0);
    check("rst_stat_mis", stat_mis, 0);
    check("rst_lk_taken", lk_taken, 0);

    rst = 1'b1;
    #1 check("rdy_after_rst", in_ready, 1);

    // back-to-back stream, out_ready held high
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].t, vecs[i].a, vecs[i].b, 32'h104, vecs[i].pr);
      @(negedge clk);
      check($sformatf("b2b%0d_valid", i), out_valid, 1);
      check($sformatf("b2b%0d_taken", i), br_taken, vecs[i].tk);
      check($sformatf("b2b%0d_mis", i), mispredict, vecs[i].mis);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("drain_valid", out_valid, 0);
    check("b2b_stat_br", stat_br, st(6));
    check("b2b_stat_mis", stat_mis, st(2));

    // backpressure
    drive(BR_LTU, 32'd1, 32'd2, 32'h104, 1'b1);
    @(negedge clk);
    check("stall_first_taken", br_taken, 1);
    drive(BR_EQ, 32'd1, 32'd2, 32'h104, 1'b1);
    out_ready = 1'b0;
    #1 check("stall_rdy0", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", k), out_valid, 1);
      check($sformatf("stall%0d_taken", k), br_taken, 1);
      check($sformatf("stall%0d_mis", k), mispredict, 0);
      check($sformatf("stall%0d_rdy", k), in_ready, 0);
    end
    out_ready = 1'b1;
    #1 check("release_rdy", in_ready, 1);
    @(negedge clk);
    check("release_valid", out_valid, 1);
    check("release_taken", br_taken, 0);
    check("release_mis", mispredict, 1);
    in_valid = 1'b0;
    @(negedge clk);
    check("release_drain", out_valid, 0);
    check("stall_stat_br", stat_br, st(8));
    check("stall_stat_mis", stat_mis, st(3));

    // BHT training at pc 0x40
    lk_pc = 32'h40;
    check("bht_init", lk_taken, 0);
    for (int k = 0; k < 4; k++) begin
      drive(BR_NE, 32'd1, 32'd2, 32'h40, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("bht_t%0d_taken", k), br_taken, 1);
      if (k == 0) check("bht_same_cycle", lk_taken, 0);
      @(negedge clk);
      check($sformatf("bht_t%0d_lk", k), lk_taken, 1);
    end
    drive(BR_EQ, 32'd1, 32'd2, 32'h40, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("bht_nt_taken", br_taken, 0);
    @(negedge clk);
    check("bht_nt_lk", lk_taken, 1);
    check("bht_stat_br", stat_br, st(13));
    check("bht_stat_mis", stat_mis, st(7));

    // reset with a pending result
    drive(BR_LT, 32'd1, 32'd2, 32'h40, 1'b1);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("pend_valid", out_valid, 1);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst2_valid", out_valid, 0);
    check("rst2_taken", br_taken, 0);
    check("rst2_mis", mispredict, 0);
    check("rst2_rdy", in_ready, 0);
    check("rst2_stat_br", stat_br, 0);
    check("rst2_stat_mis", stat_mis, 0);
    check("rst2_lk", lk_taken, 0);
    rst = 1'b1;

    // mispredicted beq, then jal
    drive(BR_EQ, 32'd5, 32'd5, 32'h80, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("beq_taken", br_taken, 1);
    check("beq_mis", mispredict, 1);
    @(negedge clk);
    check("beq_drain", out_valid, 0);
    check("beq_stat_br", stat_br, st(1));
    check("beq_stat_mis", stat_mis, st(1));
    drive(BR_ALWAYS, 32'd0, 32'd0, 32'h80, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("jal_taken", br_taken, 1);
    check("jal_mis", mispredict, 0);
    @(negedge clk);
    check("jal_stat_br", stat_br, st(1));
    check("jal_stat_mis", stat_mis, st(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
